// File: rtl/stream_dec_pkg.sv
// Shared definitions for the stream decimator/averager: mode encodings and output clamp/wrap helper.
// Build option: STREAM_DEC_AVG_SATURATE_EN selects saturation instead of wrap in sat_trunc.
package stream_dec_pkg;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    // Reduce a signed value to 'width' bits, returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                     input int width);
`ifdef STREAM_DEC_AVG_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
`else
        return (value <<< (64 - width)) >>> (64 - width);
`endif
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-deep AXI-Stream output register; upstream may push whenever the slot is empty or draining.
module stream_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    input  logic             tready
);

    // load is only legal while in_ready is high, so tdata never changes under a stalled beat.
    assign in_ready = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_dec_avg.sv
// Runtime-factor decimator for a signed AXI-Stream: pick first sample or average (sum >>> shift).
// Build option: STREAM_DEC_AVG_SATURATE_EN clamps average results instead of wrapping.
module stream_dec_avg
    import stream_dec_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEC_WIDTH   = 16,
    parameter int ACC_WIDTH   = DATA_WIDTH + DEC_WIDTH,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DEC_WIDTH-1:0]   dec,
    input  logic                   mode,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [DATA_WIDTH-1:0]  stream_i_tdata,
    input  logic                   stream_i_tvalid,
    output logic                   stream_i_tready,
    output logic [DATA_WIDTH-1:0]  stream_o_tdata,
    output logic                   stream_o_tvalid,
    input  logic                   stream_o_tready
);

    logic [DEC_WIDTH-1:0]          counter;
    logic [DEC_WIDTH-1:0]          dec_l;
    logic                          mode_l;
    logic [SHIFT_WIDTH-1:0]        shift_l;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic                          xfer;
    logic                          start;
    logic                          block_end;
    logic [DEC_WIDTH-1:0]          dec_eff;
    logic                          mode_eff;
    logic [SHIFT_WIDTH-1:0]        shift_eff;
    logic signed [ACC_WIDTH-1:0]   sample_ext;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [63:0]            shifted_64;
    logic [DATA_WIDTH-1:0]         result;

    // On the block-start beat the fresh port values apply; otherwise the latched ones do.
    always_comb begin
        xfer       = stream_i_tvalid && stream_i_tready;
        start      = (counter == '0);
        dec_eff    = start ? ((dec == '0) ? DEC_WIDTH'(1) : dec) : dec_l;
        mode_eff   = start ? mode : mode_l;
        shift_eff  = start ? shift : shift_l;
        sample_ext = {{(ACC_WIDTH-DATA_WIDTH){stream_i_tdata[DATA_WIDTH-1]}}, stream_i_tdata};
        if (start)
            acc_next = sample_ext;
        else if (mode_l == MODE_AVG)
            acc_next = acc + sample_ext;
        else
            acc_next = acc;
        shifted    = acc_next >>> shift_eff;
        shifted_64 = {{(64-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
        if (mode_eff == MODE_AVG)
            result = DATA_WIDTH'(sat_trunc(shifted_64, DATA_WIDTH));
        else
            result = acc_next[DATA_WIDTH-1:0];
        block_end  = xfer && (counter == dec_eff - DEC_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            acc     <= '0;
            dec_l   <= DEC_WIDTH'(1);
            mode_l  <= MODE_PICK;
            shift_l <= '0;
        end else if (xfer) begin
            if (start) begin
                dec_l   <= dec_eff;
                mode_l  <= mode;
                shift_l <= shift;
            end
            acc     <= acc_next;
            counter <= block_end ? '0 : counter + DEC_WIDTH'(1);
        end
    end

    stream_out_reg #(
        .WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (block_end),
        .load_data(result),
        .in_ready (stream_i_tready),
        .tdata    (stream_o_tdata),
        .tvalid   (stream_o_tvalid),
        .tready   (stream_o_tready)
    );

endmodule

// File: tb/tb_stream_dec_avg.sv
// Directed bench for stream_dec_avg: pick, average, wrap/saturate, backpressure, dec changes, reset.
module tb_stream_dec_avg;

    logic        clk;
    logic        reset;
    logic [15:0] dec;
    logic        mode;
    logic [5:0]  shift;
    logic [15:0] stream_i_tdata;
    logic        stream_i_tvalid;
    logic        stream_i_tready;
    logic [15:0] stream_o_tdata;
    logic        stream_o_tvalid;
    logic        stream_o_tready;

    int errors = 0;
    int checks = 0;

    stream_dec_avg dut (
        .clk            (clk),
        .reset          (reset),
        .dec            (dec),
        .mode           (mode),
        .shift          (shift),
        .stream_i_tdata (stream_i_tdata),
        .stream_i_tvalid(stream_i_tvalid),
        .stream_i_tready(stream_i_tready),
        .stream_o_tdata (stream_o_tdata),
        .stream_o_tvalid(stream_o_tvalid),
        .stream_o_tready(stream_o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one sample, let one edge pass, sample outputs 1 time unit later.
    task automatic send(input logic [15:0] s);
        stream_i_tdata  = s;
        stream_i_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stream_i_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d);
        check({tag, "_valid"}, 16'(stream_o_tvalid), 16'd1);
        check({tag, "_data"}, stream_o_tdata, d);
    endtask

    initial begin
        reset = 1'b1; dec = 16'd4; mode = 1'b0; shift = 6'd0;
        stream_i_tdata = '0; stream_i_tvalid = 1'b0; stream_o_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 16'(stream_o_tvalid), 16'd0);
        check("rst_data", stream_o_tdata, 16'd0);
        check("rst_iready", 16'(stream_i_tready), 16'd1);
        reset = 1'b0;

        // Pick, dec=4, ramp 0..15: output (i-3) right after input i when i%4==3.
        for (int i = 0; i < 16; i++) begin
            send(16'(i));
            check($sformatf("pick_valid_%0d", i), 16'(stream_o_tvalid), (i % 4 == 3) ? 16'd1 : 16'd0);
            if (i % 4 == 3) check($sformatf("pick_data_%0d", i), stream_o_tdata, 16'(i - 3));
        end

        // Average, dec=4, shift=2: 100>>>2=25, -32>>>2=-8.
        mode = 1'b1; shift = 6'd2;
        send(16'd10); send(16'd20); send(16'd30);
        check("avg_mid_valid", 16'(stream_o_tvalid), 16'd0);
        send(16'd40);
        expect_out("avg_25", 16'd25);
        send(-16'sd8); send(-16'sd8); send(-16'sd8); send(-16'sd8);
        expect_out("avg_m8", 16'hFFF8);

        // Average, dec=2, shift=0: 32767+32767 wraps to -2 or saturates to 32767.
        dec = 16'd2; shift = 6'd0;
        send(16'd32767); send(16'd32767);
`ifdef STREAM_DEC_AVG_SATURATE_EN
        expect_out("avg_ovf", 16'h7FFF);
`else
        expect_out("avg_ovf", 16'hFFFE);
`endif

        // Shift beyond accumulator width gives sign fill.
        dec = 16'd1; shift = 6'd40;
        send(-16'sd5);
        expect_out("shift_big_neg", 16'hFFFF);
        send(16'd5);
        expect_out("shift_big_pos", 16'h0000);
        idle();

        // Backpressure, dec=1 pick.
        mode = 1'b0; shift = 6'd0; stream_o_tready = 1'b0;
        send(16'd100);
        expect_out("bp_first", 16'd100);
        check("bp_iready_low", 16'(stream_i_tready), 16'd0);
        stream_i_tdata = 16'd101;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            expect_out($sformatf("bp_hold_%0d", c), 16'd100);
            check($sformatf("bp_iready_%0d", c), 16'(stream_i_tready), 16'd0);
        end
        stream_o_tready = 1'b1;
        #1;
        check("bp_iready_high", 16'(stream_i_tready), 16'd1);
        @(posedge clk);
        #1;
        expect_out("bp_101", 16'd101);
        send(16'd102);
        expect_out("bp_102", 16'd102);
        idle();
        check("bp_drained", 16'(stream_o_tvalid), 16'd0);

        // dec 4 -> 2 mid-block, then dec=0 acts as 1.
        dec = 16'd4;
        send(16'd1); send(16'd2);
        dec = 16'd2;
        send(16'd3);
        check("chg_mid_valid", 16'(stream_o_tvalid), 16'd0);
        send(16'd4);
        expect_out("chg_blk4", 16'd1);
        send(16'd5);
        check("chg_b2_mid", 16'(stream_o_tvalid), 16'd0);
        send(16'd6);
        expect_out("chg_blk2", 16'd5);
        dec = 16'd0;
        send(16'd7);
        expect_out("dec0_a", 16'd7);
        send(16'd8);
        expect_out("dec0_b", 16'd8);
        idle();

        // Reset after 2 of 4 average samples discards the partial sum.
        dec = 16'd4; mode = 1'b1; shift = 6'd0;
        send(16'd1000); send(16'd1000);
        stream_i_tvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_valid", 16'(stream_o_tvalid), 16'd0);
        reset = 1'b0;
        send(16'd1); send(16'd2); send(16'd3);
        check("rst2_mid", 16'(stream_o_tvalid), 16'd0);
        send(16'd4);
        expect_out("rst2_sum", 16'd10);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
